// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: ALU result stream, load-return stream and register-file write port.
// Handshake: a load return transfers on a cycle where ld_valid & ld_ready; an ALU result transfers
// on a cycle where alu_valid & ~alu_stall, otherwise the ALU holds its inputs unchanged.
interface wb_arbiter_if #(
    parameter int XLEN = 32
);
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            alu_stall;

    logic            ld_valid;
    logic            ld_ready;
    logic [4:0]      ld_rd;
    logic [2:0]      ld_funct3;
    logic [1:0]      ld_addr_lo;
    logic [XLEN-1:0] ld_word;

    logic            wb_en;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic [1:0]      lq_count;

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ld_valid, ld_rd, ld_funct3, ld_addr_lo, ld_word,
        output alu_stall, ld_ready, wb_en, wb_rd, wb_data, lq_count
    );

    modport master (
        output alu_valid, alu_rd, alu_data,
        output ld_valid, ld_rd, ld_funct3, ld_addr_lo, ld_word,
        input  alu_stall, ld_ready, wb_en, wb_rd, wb_data, lq_count
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback stage: merges ALU results and formatted load returns (2-entry FIFO) into one
// registered register-file write per cycle, never writing x0.
module wb_arbiter #(
    parameter int XLEN     = 32,
    parameter int LQ_DEPTH = 2
) (
    input logic        clk,
    input logic        rst,
    wb_arbiter_if.slave bus
);
    localparam logic [1:0] LQ_FULL = 2'(LQ_DEPTH);

    typedef struct packed {
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic [1:0]      addr_lo;
        logic [XLEN-1:0] word;
    } lq_entry_t;

    lq_entry_t       lq_mem [2];
    logic            rd_ptr;
    logic            wr_ptr;
    logic [1:0]      count;

    logic            full;
    logic            sel_alu;
    logic            deq;
    logic            enq;
    lq_entry_t       head;
    logic [XLEN-1:0] head_data;

    logic            wb_en_q;
    logic [4:0]      wb_rd_q;
    logic [XLEN-1:0] wb_data_q;

    function automatic logic [XLEN-1:0] fmt_load(input logic [2:0] funct3,
                                                  input logic [1:0] addr_lo,
                                                  input logic [XLEN-1:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{addr_lo, 3'b000} +: 8];
        h = word[{addr_lo[1], 4'b0000} +: 16];
        case (funct3)
            3'b000:  fmt_load = {{(XLEN-8){b[7]}}, b};
            3'b100:  fmt_load = {{(XLEN-8){1'b0}}, b};
            3'b001:  fmt_load = {{(XLEN-16){h[15]}}, h};
            3'b101:  fmt_load = {{(XLEN-16){1'b0}}, h};
            default: fmt_load = word;
        endcase
    endfunction

    // A full FIFO takes priority over the ALU so loads cannot starve.
    always_comb begin
        full      = (count == LQ_FULL);
        sel_alu   = bus.alu_valid & ~full;
        deq       = (count != 2'd0) & (full | ~bus.alu_valid);
        enq       = bus.ld_valid & ~full;
        head      = lq_mem[rd_ptr];
        head_data = fmt_load(head.funct3, head.addr_lo, head.word);
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            lq_mem[wr_ptr] <= '{rd: bus.ld_rd, funct3: bus.ld_funct3,
                                addr_lo: bus.ld_addr_lo, word: bus.ld_word};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (enq) wr_ptr <= ~wr_ptr;
            if (deq) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, enq} - {1'b0, deq};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_en_q   <= 1'b0;
            wb_rd_q   <= 5'd0;
            wb_data_q <= '0;
        end else if (sel_alu) begin
            wb_en_q   <= (bus.alu_rd != 5'd0);
            wb_rd_q   <= bus.alu_rd;
            wb_data_q <= bus.alu_data;
        end else if (deq) begin
            wb_en_q   <= (head.rd != 5'd0);
            wb_rd_q   <= head.rd;
            wb_data_q <= head_data;
        end else begin
            wb_en_q   <= 1'b0;
        end
    end

    assign bus.ld_ready  = ~full;
    assign bus.alu_stall = bus.alu_valid & full;
    assign bus.wb_en     = wb_en_q;
    assign bus.wb_rd     = wb_rd_q;
    assign bus.wb_data   = wb_data_q;
    assign bus.lq_count  = count;
endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: directed scenarios with constant expectations plus a randomized
// run checked against a queue-based reference model of the writeback arbitration rules.
module tb_wb_arbiter;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_pass  = 0;
  int   n_total = 0;

  wb_arbiter_if #(.XLEN(XLEN)) bus();

  wb_arbiter #(.XLEN(XLEN), .LQ_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [2:0]  f;
    logic [1:0]  a;
    logic [31:0] w;
  } load_t;

  load_t       ref_q[$];
  logic        m_en;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  logic        exp_stall, exp_ready, obs_stall, obs_ready;

  function automatic logic [31:0] ref_fmt(input logic [2:0] f, input logic [1:0] a,
                                          input logic [31:0] w);
    logic [31:0] shb;
    logic [31:0] shh;
    shb = w >> (8 * int'(a));
    shh = w >> ((a >= 2'd2) ? 16 : 0);
    case (f)
      3'd0:    return 32'($signed(shb[7:0]));
      3'd4:    return {24'd0, shb[7:0]};
      3'd1:    return 32'($signed(shh[15:0]));
      3'd5:    return {16'd0, shh[15:0]};
      default: return w;
    endcase
  endfunction

  task automatic model_reset();
    ref_q.delete();
    m_en   = 1'b0;
    m_rd   = 5'd0;
    m_data = 32'd0;
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lrd, input logic [2:0] lf,
                       input logic [1:0] la, input logic [31:0] lw);
    @(negedge clk);
    bus.alu_valid  = av;
    bus.alu_rd     = ard;
    bus.alu_data   = ad;
    bus.ld_valid   = lv;
    bus.ld_rd      = lrd;
    bus.ld_funct3  = lf;
    bus.ld_addr_lo = la;
    bus.ld_word    = lw;
  endtask

  task automatic drive_idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 3'd0, 2'd0, 32'd0);
  endtask

  // Samples combinational outputs, advances the reference model, then crosses one clock edge.
  task automatic tick();
    int    n;
    load_t e;
    #1;
    obs_stall = bus.alu_stall;
    obs_ready = bus.ld_ready;
    n = ref_q.size();
    exp_stall = bus.alu_valid && (n == 2);
    exp_ready = (n != 2);
    if (bus.alu_valid && n != 2) begin
      m_en   = (bus.alu_rd != 5'd0);
      m_rd   = bus.alu_rd;
      m_data = bus.alu_data;
    end else if (n > 0) begin
      e      = ref_q.pop_front();
      m_en   = (e.rd != 5'd0);
      m_rd   = e.rd;
      m_data = ref_fmt(e.f, e.a, e.w);
    end else begin
      m_en = 1'b0;
    end
    if (bus.ld_valid && n != 2) begin
      e.rd = bus.ld_rd; e.f = bus.ld_funct3; e.a = bus.ld_addr_lo; e.w = bus.ld_word;
      ref_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    repeat (3) begin
      drive(1'($urandom), 5'($urandom), $urandom, 1'($urandom), 5'($urandom),
            3'($urandom), 2'($urandom), $urandom);
      #1;
      n_total++; if (bus.wb_en !== 1'b0) $display("FAIL reset_wb_en: got %0b want 0", bus.wb_en); else n_pass++;
      n_total++; if (bus.wb_rd !== 5'd0) $display("FAIL reset_wb_rd: got %0d want 0", bus.wb_rd); else n_pass++;
      n_total++; if (bus.wb_data !== 32'd0) $display("FAIL reset_wb_data: got %h want 0", bus.wb_data); else n_pass++;
      n_total++; if (bus.ld_ready !== 1'b1) $display("FAIL reset_ld_ready: got %0b want 1", bus.ld_ready); else n_pass++;
      n_total++; if (bus.lq_count !== 2'd0) $display("FAIL reset_lq_count: got %0d want 0", bus.lq_count); else n_pass++;
      n_total++; if (bus.alu_stall !== 1'b0) $display("FAIL reset_alu_stall: got %0b want 0", bus.alu_stall); else n_pass++;
    end
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 5'd5, 32'h0000_1234, 1'b0, 5'd0, 3'd0, 2'd0, 32'd0);
    tick();
    n_total++;
    if (bus.wb_en !== 1'b1 || bus.wb_rd !== 5'd5 || bus.wb_data !== 32'h1234)
      $display("FAIL first_alu_write: got en=%0b rd=%0d data=%h want en=1 rd=5 data=00001234",
               bus.wb_en, bus.wb_rd, bus.wb_data);
    else n_pass++;
  endtask

  task automatic test_alu_back_to_back();
    logic [4:0]  rds [3] = '{5'd1, 5'd0, 5'd3};
    logic [31:0] ds  [3] = '{32'h11, 32'hFF, 32'h33};
    logic        ens [3] = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, rds[i], ds[i], 1'b0, 5'd0, 3'd0, 2'd0, 32'd0);
      tick();
      n_total++;
      if (bus.wb_en !== ens[i] || bus.wb_rd !== rds[i] || bus.wb_data !== ds[i])
        $display("FAIL alu_b2b_%0d: got en=%0b rd=%0d data=%h want en=%0b rd=%0d data=%h",
                 i, bus.wb_en, bus.wb_rd, bus.wb_data, ens[i], rds[i], ds[i]);
      else n_pass++;
    end
    drive_idle();
    tick();
    n_total++;
    if (bus.wb_en !== 1'b0 || bus.wb_rd !== 5'd3 || bus.wb_data !== 32'h33)
      $display("FAIL alu_idle_hold: got en=%0b rd=%0d data=%h want en=0 rd=3 data=00000033",
               bus.wb_en, bus.wb_rd, bus.wb_data);
    else n_pass++;
  endtask

  task automatic test_load_format();
    logic [2:0]  fs  [6] = '{3'd0, 3'd4, 3'd0, 3'd1, 3'd5, 3'd2};
    logic [1:0]  as  [6] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd0};
    logic [31:0] exs [6] = '{32'hFFFF_FF82, 32'h0000_0082, 32'h0000_007F,
                             32'hFFFF_80F1, 32'h0000_80F1, 32'h80F1_7F82};
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'(8 + i), fs[i], as[i], 32'h80F1_7F82);
      tick();
      n_total++;
      if (bus.lq_count !== 2'd1) $display("FAIL fmt_enq_%0d: got count=%0d want 1", i, bus.lq_count);
      else n_pass++;
      drive_idle();
      tick();
      n_total++;
      if (bus.wb_en !== 1'b1 || bus.wb_rd !== 5'(8 + i) || bus.wb_data !== exs[i])
        $display("FAIL fmt_%0d: got en=%0b rd=%0d data=%h want en=1 rd=%0d data=%h",
                 i, bus.wb_en, bus.wb_rd, bus.wb_data, 8 + i, exs[i]);
      else n_pass++;
    end
  endtask

  task automatic test_fifo_full();
    drive(1'b1, 5'd10, 32'hA0A0_0000, 1'b1, 5'd20, 3'd2, 2'd0, 32'hCAFE_0001);
    tick();
    n_total++;
    if (bus.wb_rd !== 5'd10 || bus.wb_data !== 32'hA0A0_0000 || bus.lq_count !== 2'd1)
      $display("FAIL full_c0: got rd=%0d data=%h count=%0d want rd=10 data=a0a00000 count=1",
               bus.wb_rd, bus.wb_data, bus.lq_count);
    else n_pass++;
    drive(1'b1, 5'd11, 32'hA1A1_0000, 1'b1, 5'd21, 3'd2, 2'd0, 32'hCAFE_0002);
    tick();
    n_total++;
    if (bus.wb_rd !== 5'd11 || bus.wb_data !== 32'hA1A1_0000 || bus.lq_count !== 2'd2)
      $display("FAIL full_c1: got rd=%0d data=%h count=%0d want rd=11 data=a1a10000 count=2",
               bus.wb_rd, bus.wb_data, bus.lq_count);
    else n_pass++;
    drive(1'b1, 5'd12, 32'hA2A2_0000, 1'b0, 5'd0, 3'd0, 2'd0, 32'd0);
    tick();
    n_total++;
    if (obs_stall !== 1'b1 || obs_ready !== 1'b0)
      $display("FAIL full_flags: got stall=%0b ready=%0b want stall=1 ready=0", obs_stall, obs_ready);
    else n_pass++;
    n_total++;
    if (bus.wb_en !== 1'b1 || bus.wb_rd !== 5'd20 || bus.wb_data !== 32'hCAFE_0001 || bus.lq_count !== 2'd1)
      $display("FAIL full_head_wins: got en=%0b rd=%0d data=%h count=%0d want en=1 rd=20 data=cafe0001 count=1",
               bus.wb_en, bus.wb_rd, bus.wb_data, bus.lq_count);
    else n_pass++;
    drive(1'b1, 5'd12, 32'hA2A2_0000, 1'b0, 5'd0, 3'd0, 2'd0, 32'd0);
    tick();
    n_total++;
    if (obs_stall !== 1'b0 || bus.wb_rd !== 5'd12 || bus.wb_data !== 32'hA2A2_0000)
      $display("FAIL full_alu_retry: got stall=%0b rd=%0d data=%h want stall=0 rd=12 data=a2a20000",
               obs_stall, bus.wb_rd, bus.wb_data);
    else n_pass++;
    drive_idle();
    tick();
    n_total++;
    if (bus.wb_en !== 1'b1 || bus.wb_rd !== 5'd21 || bus.wb_data !== 32'hCAFE_0002 || bus.lq_count !== 2'd0)
      $display("FAIL full_second_load: got en=%0b rd=%0d data=%h count=%0d want en=1 rd=21 data=cafe0002 count=0",
               bus.wb_en, bus.wb_rd, bus.wb_data, bus.lq_count);
    else n_pass++;
    drive_idle();
    tick();
    n_total++;
    if (bus.wb_en !== 1'b0) $display("FAIL full_no_dup: got en=%0b want 0", bus.wb_en);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd14, 3'd2, 2'd0, 32'h1111_2222);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd15, 3'd2, 2'd0, 32'h3333_4444);
    tick();
    n_total++;
    if (bus.lq_count !== 2'd1 || bus.wb_rd !== 5'd14 || bus.wb_data !== 32'h1111_2222)
      $display("FAIL simul_enq_deq: got count=%0d rd=%0d data=%h want count=1 rd=14 data=11112222",
               bus.lq_count, bus.wb_rd, bus.wb_data);
    else n_pass++;
    drive_idle();
    tick();
    n_total++;
    if (bus.lq_count !== 2'd0 || bus.wb_rd !== 5'd15 || bus.wb_data !== 32'h3333_4444)
      $display("FAIL simul_second: got count=%0d rd=%0d data=%h want count=0 rd=15 data=33334444",
               bus.lq_count, bus.wb_rd, bus.wb_data);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 5'd1, 32'h0101_0101, 1'b1, 5'd16, 3'd2, 2'd0, 32'hDEAD_0016);
    tick();
    drive(1'b1, 5'd2, 32'h0202_0202, 1'b1, 5'd17, 3'd2, 2'd0, 32'hDEAD_0017);
    tick();
    n_total++;
    if (bus.lq_count !== 2'd2) $display("FAIL rmid_fill: got count=%0d want 2", bus.lq_count);
    else n_pass++;
    drive_idle();
    rst = 1'b0;
    #1;
    n_total++;
    if (bus.lq_count !== 2'd0 || bus.wb_en !== 1'b0 || bus.ld_ready !== 1'b1)
      $display("FAIL rmid_async: got count=%0d en=%0b ready=%0b want count=0 en=0 ready=1",
               bus.lq_count, bus.wb_en, bus.ld_ready);
    else n_pass++;
    #2;
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      drive_idle();
      tick();
      n_total++;
      if (bus.wb_en !== 1'b0 || bus.lq_count !== 2'd0)
        $display("FAIL rmid_after_%0d: got en=%0b count=%0d want en=0 count=0", i, bus.wb_en, bus.lq_count);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic        av, lv;
    logic [4:0]  ard, lrd;
    logic [31:0] ad, lw;
    logic [2:0]  lf;
    logic [1:0]  la;
    int          errs;
    obs_stall = 1'b0;
    av = 1'b0; ard = 5'd0; ad = 32'd0;
    errs = 0;
    for (int i = 0; i < 400; i++) begin
      if (!obs_stall) begin
        av  = ($urandom_range(0, 3) != 0);
        ard = 5'($urandom_range(0, 31));
        ad  = $urandom;
      end
      lv  = 1'($urandom_range(0, 1));
      lrd = 5'($urandom_range(0, 31));
      lf  = 3'($urandom_range(0, 7));
      la  = 2'($urandom_range(0, 3));
      lw  = $urandom;
      drive(av, ard, ad, lv, lrd, lf, la, lw);
      tick();
      n_total++;
      if (obs_stall !== exp_stall || obs_ready !== exp_ready) begin
        if (errs < 10) $display("FAIL rand_flags_%0d: got stall=%0b ready=%0b want stall=%0b ready=%0b",
                                i, obs_stall, obs_ready, exp_stall, exp_ready);
        errs++;
      end else n_pass++;
      n_total++;
      if (bus.wb_en !== m_en || bus.wb_rd !== m_rd || bus.wb_data !== m_data ||
          bus.lq_count !== 2'(ref_q.size())) begin
        if (errs < 10) $display("FAIL rand_wb_%0d: got en=%0b rd=%0d data=%h count=%0d want en=%0b rd=%0d data=%h count=%0d",
                                i, bus.wb_en, bus.wb_rd, bus.wb_data, bus.lq_count,
                                m_en, m_rd, m_data, ref_q.size());
        errs++;
      end else n_pass++;
    end
  endtask

  initial begin
    bus.alu_valid  = 1'b0;
    bus.alu_rd     = 5'd0;
    bus.alu_data   = 32'd0;
    bus.ld_valid   = 1'b0;
    bus.ld_rd      = 5'd0;
    bus.ld_funct3  = 3'd0;
    bus.ld_addr_lo = 2'd0;
    bus.ld_word    = 32'd0;
    test_reset();
    test_alu_back_to_back();
    test_load_format();
    test_fifo_full();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
